// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-port RAM between instruction fetch and data access.
// Bounded data priority keeps fetch from starving; flush cancels in-flight fetches.
module unified_mem_arbiter #(
   parameter int unsigned AW           = 10,
   parameter int unsigned DW           = 32,
   parameter int unsigned MAX_DATA_RUN = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   input  logic          flush,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata,
   output logic          stall_if,
   output logic          stall_mem
);

   localparam int unsigned RUN_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IF_ACC = 2'd1,
      D_RD   = 2'd2,
      D_WR   = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [RUN_W-1:0]   run_cnt_q;
   logic [AW-1:0]      addr_q;
   logic [DW-1:0]      wdata_q;
   logic [DW-1:0]      if_rdata_q, d_rdata_q;
   logic               if_rvalid_q, d_rvalid_q;
   logic               run_full_c, if_gnt_c, d_gnt_c;

   // Arbitration and next-state: the state names the access owning the RAM next cycle
   always_comb begin
      run_full_c = 1'b0;
      d_gnt_c    = 1'b0;
      if_gnt_c   = 1'b0;
      state_d    = IDLE;
      run_full_c = (run_cnt_q == RUN_W'(MAX_DATA_RUN));
      d_gnt_c    = d_req & ~(if_req & ~flush & run_full_c);
      if_gnt_c   = ~d_gnt_c & if_req & ~flush;
      if (d_gnt_c) begin
         state_d = d_we ? D_WR : D_RD;
      end else if (if_gnt_c) begin
         state_d = IF_ACC;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Access payload captured on the grant edge; held while idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (d_gnt_c) begin
         addr_q  <= d_addr;
         wdata_q <= d_wdata;
      end else if (if_gnt_c) begin
         addr_q  <= if_addr;
      end
   end

   // Read data capture at the end of the access cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
      end else begin
         if_rvalid_q <= (state_q == IF_ACC) & ~flush;
         d_rvalid_q  <= (state_q == D_RD);
         if (state_q == IF_ACC) begin
            if_rdata_q <= ram_rdata;
         end
         if (state_q == D_RD) begin
            d_rdata_q <= ram_rdata;
         end
      end
   end

   // Consecutive data grants while fetch waits; saturates at the limit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_cnt_q <= '0;
      end else if (if_gnt_c || !if_req) begin
         run_cnt_q <= '0;
      end else if (d_gnt_c && !run_full_c) begin
         run_cnt_q <= run_cnt_q + RUN_W'(1);
      end
   end

   assign if_gnt    = rst_n & if_gnt_c;
   assign d_gnt     = rst_n & d_gnt_c;
   assign stall_if  = rst_n & if_req & ~if_gnt_c;
   assign stall_mem = rst_n & d_req & ~d_gnt_c;
   assign if_rvalid = if_rvalid_q & ~flush;
   assign if_rdata  = if_rdata_q;
   assign d_rvalid  = d_rvalid_q;
   assign d_rdata   = d_rdata_q;
   assign ram_we    = (state_q == D_WR);
   assign ram_addr  = addr_q;
   assign ram_wdata = wdata_q;

endmodule
